// File: rtl/nivel2_mag_controle_pkg.sv
// Shared types and constants for the magnetron enable controller:
// FSM states, stop-cause codes and the safe reset values of the synchronized inputs.
package mag_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COOKING = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_USER  = 2'd1,
    CAUSE_DOOR  = 2'd2,
    CAUSE_TIMER = 2'd3
  } cause_t;

  localparam logic RST_STARTN      = 1'b1;
  localparam logic RST_STOPN       = 1'b1;
  localparam logic RST_CLEARN      = 1'b1;
  localparam logic RST_DOOR_CLOSED = 1'b0;
  localparam logic RST_TIMER_DONE  = 1'b0;

  // Exit reason when several causes coincide: door beats timer beats user.
  function automatic cause_t exit_cause(input logic door_closed, input logic timer_done);
    cause_t c;
    if (!door_closed) begin
      c = CAUSE_DOOR;
    end else if (timer_done) begin
      c = CAUSE_TIMER;
    end else begin
      c = CAUSE_USER;
    end
    return c;
  endfunction

endpackage

// File: rtl/nivel2_mag_controle_if.sv
// Panel/interlock inputs and magnetron status outputs of the controller.
// The slave side is the controller; the master side drives the buttons and switches.
interface nivel2_mag_controle_if;

  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       timer_done;
  logic       mag_on;
  logic [1:0] stop_cause;

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done,
    output mag_on, stop_cause
  );

  modport master (
    output startn, stopn, clearn, door_closed, timer_done,
    input  mag_on, stop_cause
  );

endinterface

// File: rtl/nivel2_mag_controle_sync.sv
// Single-bit multi-flop synchronizer; on reset every stage loads RST_VAL so the
// controller sees a safe input value until real samples have propagated.
module mag_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sh;

  // Shift chain, oldest sample at the top bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh <= {STAGES{RST_VAL}};
    end else begin
      r_sh <= {r_sh[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sh[STAGES-1];

endmodule

// File: rtl/nivel2_mag_controle.sv
// Magnetron enable controller: synchronizes the panel inputs, latches COOKING on START
// and drops it on STOP/CLEAR/door open/timer done, recording why the cook ended.
module nivel2_mag_controle
  import mag_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  nivel2_mag_controle_if.slave   bus
);

  logic   w_startn;
  logic   w_stopn;
  logic   w_clearn;
  logic   w_door_closed;
  logic   w_timer_done;
  logic   w_set;
  logic   w_clr;
  state_t r_state;
  logic   r_mag_on;
  cause_t r_cause;

  mag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RST_STARTN)) u_sync_startn (
    .clk(clk), .reset(reset), .i_d(bus.startn), .o_q(w_startn));
  mag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RST_STOPN)) u_sync_stopn (
    .clk(clk), .reset(reset), .i_d(bus.stopn), .o_q(w_stopn));
  mag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RST_CLEARN)) u_sync_clearn (
    .clk(clk), .reset(reset), .i_d(bus.clearn), .o_q(w_clearn));
  mag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RST_DOOR_CLOSED)) u_sync_door (
    .clk(clk), .reset(reset), .i_d(bus.door_closed), .o_q(w_door_closed));
  mag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RST_TIMER_DONE)) u_sync_timer (
    .clk(clk), .reset(reset), .i_d(bus.timer_done), .o_q(w_timer_done));

  assign w_set = ~w_startn & w_door_closed & ~w_timer_done;
  assign w_clr = ~w_stopn | ~w_clearn | ~w_door_closed | w_timer_done;

  // Cook FSM; mag_on is registered alongside the state so it is 1 exactly in COOKING.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mag_on <= 1'b0;
      r_cause  <= CAUSE_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_set & ~w_clr) begin
            r_state  <= COOKING;
            r_mag_on <= 1'b1;
            r_cause  <= CAUSE_NONE;
          end else begin
            r_mag_on <= 1'b0;
          end
        end
        COOKING: begin
          if (w_clr) begin
            r_state  <= IDLE;
            r_mag_on <= 1'b0;
            r_cause  <= exit_cause(w_door_closed, w_timer_done);
          end else begin
            r_mag_on <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_mag_on <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mag_on     = r_mag_on;
  assign bus.stop_cause = r_cause;

endmodule

// File: tb/tb_nivel2_mag_controle.sv
// Bench for nivel2_mag_controle: directed table, latency/reset sequences and a
// randomized run compared against a delay-queue reference model.
module tb_nivel2_mag_controle;

  localparam int       STAGES  = 2;
  localparam logic [4:0] DEF_IN = 5'b11100; // startn stopn clearn door timer

  typedef struct {
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door;
    logic       timer;
    logic       exp_mag;
    logic [1:0] exp_cause;
    string      name;
  } vec_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  logic [4:0] m_q[$];
  logic       m_cook;
  logic [1:0] m_cause;
  vec_t       vecs[$];

  nivel2_mag_controle_if bus ();

  nivel2_mag_controle #(.SYNC_STAGES(STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic p, input logic c, input logic d,
                              input logic t, input logic em, input logic [1:0] ec,
                              input string nm);
    vec_t v;
    v.startn = s; v.stopn = p; v.clearn = c; v.door = d; v.timer = t;
    v.exp_mag = em; v.exp_cause = ec; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic c, input logic d, input logic t);
    bus.startn = s; bus.stopn = p; bus.clearn = c; bus.door_closed = d; bus.timer_done = t;
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < STAGES; i++) m_q.push_back(DEF_IN);
    m_cook  = 1'b0;
    m_cause = 2'd0;
  endtask

  // Model: the FSM sees the input vector from STAGES edges ago.
  task automatic model_step();
    logic [4:0] d;
    logic set_c, clr_c;
    d = m_q.pop_front();
    m_q.push_back({bus.startn, bus.stopn, bus.clearn, bus.door_closed, bus.timer_done});
    set_c = !d[4] && d[1] && !d[0];
    clr_c = !d[3] || !d[2] || !d[1] || d[0];
    if (!m_cook && set_c && !clr_c) begin
      m_cook  = 1'b1;
      m_cause = 2'd0;
    end else if (m_cook && clr_c) begin
      m_cook  = 1'b0;
      m_cause = !d[1] ? 2'd2 : (d[0] ? 2'd3 : 2'd1);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic async_reset_check(input string nm);
    #2 reset = 1'b1;
    #1;
    check({nm, "_mag"}, bus.mag_on, 0);
    check({nm, "_cause"}, bus.stop_cause, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_mag", bus.mag_on, 0);
    check("reset_cause", bus.stop_cause, 0);

    //      startn stopn clearn door timer  mag cause
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "start_press"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "start_release"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, "door_open"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, "door_reclose"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "restart1"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, "timer_done"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, "start_with_timer"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, "idle_hold"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "restart2"));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, "stop"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, "start_and_stop"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "restart3"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, "clear"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, "start_door_open"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "restart4"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, "door_and_timer"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "restart5"));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, "timer_and_stop"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, "final_idle"));

    foreach (vecs[i]) begin
      drive(vecs[i].startn, vecs[i].stopn, vecs[i].clearn, vecs[i].door, vecs[i].timer);
      tick(3);
      check({vecs[i].name, "_mag"}, bus.mag_on, int'(vecs[i].exp_mag));
      check({vecs[i].name, "_cause"}, bus.stop_cause, int'(vecs[i].exp_cause));
    end

    // Latency: START reaches mag_on on the third edge, not earlier.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(2);
    check("lat_start_early", bus.mag_on, 0);
    tick(1);
    check("lat_start_edge3", bus.mag_on, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(3);
    check("lat_start_hold", bus.mag_on, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(2);
    check("lat_door_early", bus.mag_on, 1);
    tick(1);
    check("lat_door_edge3", bus.mag_on, 0);
    check("lat_door_cause", bus.stop_cause, 2);

    // Reset asserted mid-cook takes effect without a clock edge.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(3);
    check("precook_mag", bus.mag_on, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    async_reset_check("midcook_reset");
    tick(3);
    check("post_reset_idle", bus.mag_on, 0);

    // Randomized run against the reference model.
    for (int blk = 0; blk < 150; blk++) begin
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 6) != 0),
            logic'($urandom_range(0, 9) == 0));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        tick(1);
        check("rand_mag", bus.mag_on, int'(m_cook));
        check("rand_cause", bus.stop_cause, int'(m_cause));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
